// File: rtl/hdmi_timing_rx_if.sv
// Video sink bundle: raw de/hs/vs/rgb in, tagged pixels and timing status out.
// CW/FCW must match the parameters of the hdmi_timing_rx instance.
interface hdmi_timing_rx_if #(
  parameter int unsigned CW  = 11,
  parameter int unsigned FCW = 8
);
  logic          in_de;
  logic          in_hs;
  logic          in_vs;
  logic [7:0]    in_r;
  logic [7:0]    in_g;
  logic [7:0]    in_b;

  logic          out_de;
  logic [7:0]    out_r;
  logic [7:0]    out_g;
  logic [7:0]    out_b;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic          out_sof;
  logic          out_eol;
  logic [CW-1:0] hres;
  logic [CW-1:0] vres;
  logic          locked;
  logic          err;
  logic [FCW-1:0] frame_cnt;

  // video source side
  modport master (
    output in_de, in_hs, in_vs, in_r, in_g, in_b,
    input  out_de, out_r, out_g, out_b, out_x, out_y, out_sof, out_eol,
    input  hres, vres, locked, err, frame_cnt
  );

  // timing receiver side
  modport slave (
    input  in_de, in_hs, in_vs, in_r, in_g, in_b,
    output out_de, out_r, out_g, out_b, out_x, out_y, out_sof, out_eol,
    output hres, vres, locked, err, frame_cnt
  );
endinterface

// File: rtl/hdmi_timing_rx.sv
// Video timing receiver: measures active resolution, locks on repeated identical
// frames and forwards pixels tagged with x/y and SOF/EOL after a 2-cycle pipe.
module hdmi_timing_rx #(
  parameter int unsigned CW          = 11,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned FCW         = 8
) (
  input logic             clk,
  input logic             rst,
  hdmi_timing_rx_if.slave vid
);

  localparam int unsigned   MW   = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // stage 1 input registers and previous-cycle copies for edge detection
  logic       de1, hs1, vs1;
  logic [7:0] r1, g1, b1;
  logic       de2, vs2;

  // per-line / per-frame measurement state
  logic [CW-1:0] xc;
  logic [CW-1:0] yc;
  logic [CW-1:0] first_w;
  logic          have_w;
  logic          frame_bad;
  logic          sof_pend;
  logic          dv_q;
  logic          xo_q;

  // lock FSM state
  state_t         state, state_n;
  logic [MW-1:0]  match_cnt, match_n;
  logic [CW-1:0]  ref_w, ref_h, ref_w_n, ref_h_n;
  logic [CW-1:0]  hres_n, vres_n;
  logic           locked_n;
  logic [FCW-1:0] fc_n;
  logic           lock_err;

  // decoded events for the stage-1 sample
  logic          de_rise, de_fall, vs_rise;
  logic          dv, dv_pulse;
  logic          x_ovf, x_ovf_pulse, y_ovf, w_mis;
  logic          viol_lvl, viol_pulse;
  logic [CW-1:0] x_pix, y_pix;
  logic [CW-1:0] line_w, line_h;
  logic          frame_ok, dim_match;
  logic          sof_now;

  always_comb begin
    de_rise     = de1 & ~de2;
    de_fall     = ~de1 & de2;
    vs_rise     = vs1 & ~vs2;
    dv          = de1 & (vs1 | hs1);
    dv_pulse    = dv & ~dv_q;
    x_ovf       = de1 & ~de_rise & (xc == CMAX);
    x_ovf_pulse = x_ovf & ~xo_q;
    y_ovf       = de_fall & (yc == CMAX);
    w_mis       = de_fall & have_w & (xc != first_w);
    viol_lvl    = dv | x_ovf | y_ovf | w_mis;
    viol_pulse  = dv_pulse | x_ovf_pulse | y_ovf | w_mis;
    x_pix       = de_rise ? '0 : xc;
    y_pix       = vs_rise ? '0 : yc;
    sof_now     = de1 & (sof_pend | vs_rise);
    // a line ending in the vs_rise cycle still belongs to the closing frame
    line_w      = have_w ? first_w : (de_fall ? xc : '0);
    line_h      = (de_fall && !y_ovf) ? yc + CW'(1) : yc;
    frame_ok    = (line_w != '0) & (line_h != '0) & ~frame_bad & ~viol_lvl;
    dim_match   = (line_w == ref_w) & (line_h == ref_h);
  end

  // input pipe, line/frame measurement and pixel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      r1          <= '0;
      g1          <= '0;
      b1          <= '0;
      de2         <= 1'b0;
      vs2         <= 1'b0;
      dv_q        <= 1'b0;
      xo_q        <= 1'b0;
      xc          <= '0;
      yc          <= '0;
      first_w     <= '0;
      have_w      <= 1'b0;
      frame_bad   <= 1'b0;
      sof_pend    <= 1'b0;
      vid.out_de  <= 1'b0;
      vid.out_r   <= '0;
      vid.out_g   <= '0;
      vid.out_b   <= '0;
      vid.out_x   <= '0;
      vid.out_y   <= '0;
      vid.out_sof <= 1'b0;
      vid.out_eol <= 1'b0;
    end else begin
      de1  <= vid.in_de;
      hs1  <= vid.in_hs;
      vs1  <= vid.in_vs;
      r1   <= vid.in_r;
      g1   <= vid.in_g;
      b1   <= vid.in_b;
      de2  <= de1;
      vs2  <= vs1;
      dv_q <= dv;
      xo_q <= x_ovf;

      if (de_rise)                xc <= CW'(1);
      else if (de1 && !x_ovf)     xc <= xc + CW'(1);

      if (vs_rise)                yc <= '0;
      else if (de_fall && !y_ovf) yc <= yc + CW'(1);

      if (vs_rise) begin
        have_w <= 1'b0;
      end else if (de_fall && !have_w) begin
        have_w  <= 1'b1;
        first_w <= xc;
      end

      if (vs_rise)       frame_bad <= 1'b0;
      else if (viol_lvl) frame_bad <= 1'b1;

      if (vs_rise && !de1) sof_pend <= 1'b1;
      else if (de1)        sof_pend <= 1'b0;

      vid.out_de  <= de1;
      vid.out_r   <= r1;
      vid.out_g   <= g1;
      vid.out_b   <= b1;
      vid.out_x   <= de1 ? x_pix : '0;
      vid.out_y   <= y_pix;
      vid.out_sof <= sof_now;
      // the raw input is the next pixel's de, giving the one-pixel look-ahead
      vid.out_eol <= de1 & ~vid.in_de;
    end
  end

  // lock FSM state and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEARCH;
      match_cnt     <= '0;
      ref_w         <= '0;
      ref_h         <= '0;
      vid.hres      <= '0;
      vid.vres      <= '0;
      vid.locked    <= 1'b0;
      vid.frame_cnt <= '0;
      vid.err       <= 1'b0;
    end else begin
      state         <= state_n;
      match_cnt     <= match_n;
      ref_w         <= ref_w_n;
      ref_h         <= ref_h_n;
      vid.hres      <= hres_n;
      vid.vres      <= vres_n;
      vid.locked    <= locked_n;
      vid.frame_cnt <= fc_n;
      vid.err       <= viol_pulse | lock_err;
    end
  end

  // frame-close decisions, taken only on vs_rise
  always_comb begin
    state_n  = state;
    match_n  = match_cnt;
    ref_w_n  = ref_w;
    ref_h_n  = ref_h;
    hres_n   = vid.hres;
    vres_n   = vid.vres;
    locked_n = vid.locked;
    fc_n     = vid.frame_cnt;
    lock_err = 1'b0;

    if (vs_rise) begin
      case (state)
        SEARCH: begin
          state_n = ACQUIRE;
          match_n = '0;
        end
        ACQUIRE: begin
          if (frame_ok && dim_match) begin
            match_n = match_cnt + MW'(1);
          end else if (frame_ok) begin
            ref_w_n = line_w;
            ref_h_n = line_h;
            match_n = MW'(1);
          end else begin
            match_n = '0;
          end
          if (match_n >= MW'(LOCK_FRAMES)) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
            hres_n   = ref_w_n;
            vres_n   = ref_h_n;
          end
        end
        LOCKED: begin
          if (frame_ok && dim_match) begin
            fc_n = vid.frame_cnt + FCW'(1);
          end else begin
            state_n  = SEARCH;
            locked_n = 1'b0;
            lock_err = 1'b1;
          end
        end
        default: begin
          state_n  = SEARCH;
          locked_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_timing_rx.sv
// Directed bench for hdmi_timing_rx on a scaled-down raster; pixels are checked
// through an expected-pixel queue filled as stimulus is driven.
module tb_hdmi_timing_rx;

  localparam int unsigned CW  = 11;
  localparam int unsigned FCW = 8;
  localparam int HS  = 2;
  localparam int HBP = 8;
  localparam int HFP = 8;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VFP = 2;
  localparam int W   = 32;
  localparam int H   = 16;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          eol;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic [31:0]   cyc;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  hdmi_timing_rx_if #(.CW(CW), .FCW(FCW)) vid ();

  hdmi_timing_rx #(.CW(CW), .LOCK_FRAMES(2), .FCW(FCW)) dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  pix_t        sb_q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          err_seen = 0;
  int unsigned tcyc     = 0;
  bit          sb_en    = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sample outputs on the falling edge, then advance to just after the next rise
  task automatic step();
    pix_t got;
    pix_t exp;
    @(negedge clk);
    if (vid.err === 1'b1) err_seen++;
    if (vid.out_de === 1'b1 && sb_en) begin
      got.x   = vid.out_x;
      got.y   = vid.out_y;
      got.sof = vid.out_sof;
      got.eol = vid.out_eol;
      got.r   = vid.out_r;
      got.g   = vid.out_g;
      got.b   = vid.out_b;
      got.cyc = tcyc;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL pixel_extra got x=%0d y=%0d exp=none", got.x, got.y);
      end
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        checks++;
        assert (got === exp) else begin
          errors++;
          $error("FAIL pixel got x=%0d y=%0d sof=%0b eol=%0b rgb=%h%h%h cyc=%0d exp x=%0d y=%0d sof=%0b eol=%0b rgb=%h%h%h cyc=%0d",
                 got.x, got.y, got.sof, got.eol, got.r, got.g, got.b, got.cyc,
                 exp.x, exp.y, exp.sof, exp.eol, exp.r, exp.g, exp.b, exp.cyc);
        end
      end
    end
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic reset_zero_checks();
    check("rst_out_de", 32'(vid.out_de), 32'd0);
    check("rst_out_x", 32'(vid.out_x), 32'd0);
    check("rst_out_sof", 32'(vid.out_sof), 32'd0);
    check("rst_locked", 32'(vid.locked), 32'd0);
    check("rst_hres", 32'(vid.hres), 32'd0);
    check("rst_vres", 32'(vid.vres), 32'd0);
    check("rst_frame_cnt", 32'(vid.frame_cnt), 32'd0);
    check("rst_err", 32'(vid.err), 32'd0);
  endtask

  // one raster line; active lines push their expected pixels
  task automatic line(input int w, input bit vs, input bit active, input int y,
                      input int rst_at, input bit burst);
    for (int i = 0; i < HS + HBP + w + HFP; i++) begin
      int   x;
      bit   de;
      pix_t e;
      x  = i - HS - HBP;
      de = (active || burst) && x >= 0 && x < w;
      vid.in_hs = (i < HS);
      vid.in_vs = vs;
      vid.in_de = de;
      vid.in_r  = de ? 8'(x) : 8'h00;
      vid.in_g  = de ? 8'(y) : 8'h00;
      vid.in_b  = de ? 8'($urandom) : 8'h00;
      if (de && active && sb_en) begin
        e.x   = CW'(x);
        e.y   = CW'(y);
        e.sof = (x == 0 && y == 0);
        e.eol = (x == w - 1);
        e.r   = vid.in_r;
        e.g   = vid.in_g;
        e.b   = vid.in_b;
        e.cyc = tcyc + 2;
        sb_q.push_back(e);
      end
      if (rst_at >= 0 && i == rst_at) begin
        rst = 1'b1;
        #1;
        reset_zero_checks();
      end
      if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
      step();
    end
  endtask

  task automatic vsync(input int w, input bit burst);
    for (int l = 0; l < VS; l++) line(w, 1'b1, 1'b0, 0, -1, burst && l == 1);
  endtask

  task automatic body(input int w, input int h, input int short_line, input int rst_line);
    for (int l = 0; l < VBP; l++) line(w, 1'b0, 1'b0, 0, -1, 1'b0);
    for (int l = 0; l < h; l++)
      line((l == short_line) ? w - 1 : w, 1'b0, 1'b1, l,
           (l == rst_line) ? HS + HBP + w / 2 : -1, 1'b0);
    for (int l = 0; l < VFP; l++) line(w, 1'b0, 1'b0, 0, -1, 1'b0);
  endtask

  initial begin
    int base;
    vid.in_de = 1'b0;
    vid.in_hs = 1'b0;
    vid.in_vs = 1'b0;
    vid.in_r  = 8'h00;
    vid.in_g  = 8'h00;
    vid.in_b  = 8'h00;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_zero_checks();
    rst = 1'b0;

    // clean stream: lock at the vs_rise closing frame 2
    vsync(W, 1'b0);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("lock_after_f1", 32'(vid.locked), 32'd0);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("lock_after_f2", 32'(vid.locked), 32'd1);
    check("hres", 32'(vid.hres), 32'(W));
    check("vres", 32'(vid.vres), 32'(H));
    check("frame_cnt_at_lock", 32'(vid.frame_cnt), 32'd0);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("frame_cnt_1", 32'(vid.frame_cnt), 32'd1);
    check("err_clean", 32'(err_seen), 32'd0);

    // one short line while locked
    body(W, H, 10, -1);
    check("err_short_line", 32'(err_seen), 32'd1);
    vsync(W, 1'b0);
    check("lock_drop", 32'(vid.locked), 32'd0);
    check("err_lock_drop", 32'(err_seen), 32'd2);
    check("hres_hold", 32'(vid.hres), 32'(W));
    check("frame_cnt_drop", 32'(vid.frame_cnt), 32'd1);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("relock_search", 32'(vid.locked), 32'd0);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("relock_acq1", 32'(vid.locked), 32'd0);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("relock", 32'(vid.locked), 32'd1);
    check("frame_cnt_held", 32'(vid.frame_cnt), 32'd1);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("frame_cnt_2", 32'(vid.frame_cnt), 32'd2);
    check("err_after_relock", 32'(err_seen), 32'd2);

    // reset pulse mid-line, then a frame with de during vsync while acquiring
    sb_en = 1'b0;
    body(W, H, -1, 5);
    sb_en = 1'b1;
    vsync(W, 1'b0);
    check("post_rst_unlocked", 32'(vid.locked), 32'd0);
    base = err_seen;
    body(W, H, -1, -1);
    sb_en = 1'b0;
    vsync(W, 1'b1);
    body(W, H, -1, -1);
    check("err_de_in_vs", 32'(err_seen), 32'(base + 1));
    sb_en = 1'b1;
    vsync(W, 1'b0);
    check("bad_frame_no_lock", 32'(vid.locked), 32'd0);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("acq_again", 32'(vid.locked), 32'd0);
    body(W, H, -1, -1);
    vsync(W, 1'b0);
    check("lock_post_rst", 32'(vid.locked), 32'd1);
    check("frame_cnt_post_rst", 32'(vid.frame_cnt), 32'd0);
    check("err_post_rst", 32'(err_seen), 32'(base + 1));

    // resolution switch to 64x64 at a frame boundary
    base = err_seen;
    body(64, 64, -1, -1);
    vsync(64, 1'b0);
    check("switch_unlock", 32'(vid.locked), 32'd0);
    check("switch_err", 32'(err_seen), 32'(base + 1));
    check("switch_hres_hold", 32'(vid.hres), 32'(W));
    check("switch_vres_hold", 32'(vid.vres), 32'(H));
    body(64, 64, -1, -1);
    vsync(64, 1'b0);
    body(64, 64, -1, -1);
    vsync(64, 1'b0);
    check("switch_acq", 32'(vid.locked), 32'd0);
    body(64, 64, -1, -1);
    vsync(64, 1'b0);
    check("switch_lock", 32'(vid.locked), 32'd1);
    check("switch_hres", 32'(vid.hres), 32'd64);
    check("switch_vres", 32'(vid.vres), 32'd64);
    check("switch_err_once", 32'(err_seen), 32'(base + 1));
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
